// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Types and mode constants shared between the SPI master and the SPI slave.
//   spi_slave_state_t : slave frame FSM states (S_IDLE, S_SHIFT)
//   SPI_CPOL_* / SPI_CPHA_* : clock polarity / phase selectors
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } spi_slave_state_t;

  // SCLK idle level
  localparam bit SPI_CPOL_IDLE_LOW  = 1'b0;
  localparam bit SPI_CPOL_IDLE_HIGH = 1'b1;

  // Which SCLK edge samples data
  localparam bit SPI_CPHA_LEADING   = 1'b0;
  localparam bit SPI_CPHA_TRAILING  = 1'b1;

endpackage

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Parallel word interface of the SPI slave.
//   tx_data/tx_load  -> transmit word and its capture strobe
//   tx_ready         <- transmit buffer empty
//   rx_data/rx_valid <- received word and its one-cycle update pulse
//   busy, frame_done <- frame status
//   tx_underrun      <- only when SPI_SLAVE_UNDERRUN_EN is defined
// Modport master: the user logic side. Modport slave: the spi_slave side.
// -----------------------------------------------------------------------------
interface spi_slave_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              frame_done;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic              tx_underrun;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, busy, frame_done, tx_underrun
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, busy, frame_done, tx_underrun
  );
`else
  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, busy, frame_done
  );
`endif

endinterface

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Two-flop synchronizer, W bits wide, for asynchronous pins.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous inputs
//   q        : synchronized outputs (reset to RST_VAL)
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage metastability filter
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI target endpoint. Oversamples SCLK/CS_N/MOSI in the clk domain,
// deserialises MOSI words (MSB first) and serialises a one-word transmit
// buffer onto MISO.
//   clk, rst        : system clock (>= 8x SCLK), synchronous active-high reset
//   spi_sclk/cs_n/mosi : asynchronous SPI pins from the master
//   spi_miso        : slave data out, 0 while deselected
//   bus             : spi_slave_if.slave word/status interface
// Optional build macro SPI_SLAVE_UNDERRUN_EN adds bus.tx_underrun, a one-clk
// pulse at every word start that finds the transmit buffer empty.
// -----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit CPOL   = SPI_CPOL_IDLE_LOW,
  parameter bit CPHA   = SPI_CPHA_LEADING
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  spi_slave_if.slave bus
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [2:0]        pins_s;
  logic [2:0]        sync_s;
  logic              sclk_s, cs_n_s, mosi_s;
  logic              sclk_d_r, cs_d_r;
  logic              sclk_rise_s, sclk_fall_s, lead_s, trail_s;
  logic              sample_s, shift_s, cs_fall_s, cs_rise_s;

  spi_slave_state_t  state_r, state_nxt_s;
  logic              start_frame_s, word_start_s, do_sample_s, do_shift_s;
  logic              skip_clr_s, frame_end_s, load_ok_s;

  logic [BW-1:0]     bit_cnt_r;
  logic              word_bnd_r, skip_lead_r;
  logic [DATA_W-1:0] rx_shift_r, tx_shift_r, tx_buf_r, rx_data_r;
  logic              tx_ready_r, rx_valid_r, busy_r, frame_done_r, miso_r;

  // cs_n synchronizes from 0 so that a fall is only recognised after the pin
  // has been seen high: the block never joins a frame already in progress.
  assign pins_s = {spi_sclk, spi_cs_n, spi_mosi};

  spi_sync #(
    .W       (3),
    .RST_VAL ({CPOL, 1'b0, 1'b0})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins_s),
    .q   (sync_s)
  );

  assign sclk_s = sync_s[2];
  assign cs_n_s = sync_s[1];
  assign mosi_s = sync_s[0];

  // Third SCLK flop and CS_N history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d_r <= CPOL;
      cs_d_r   <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
      cs_d_r   <= cs_n_s;
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign lead_s      = CPOL ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = CPOL ? sclk_rise_s : sclk_fall_s;
  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign cs_fall_s   = cs_d_r & ~cs_n_s;
  assign cs_rise_s   = ~cs_d_r & cs_n_s;
  assign load_ok_s   = bus.tx_load & tx_ready_r;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-cycle datapath commands
  always_comb begin
    state_nxt_s   = state_r;
    start_frame_s = 1'b0;
    word_start_s  = 1'b0;
    do_sample_s   = 1'b0;
    do_shift_s    = 1'b0;
    skip_clr_s    = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s   = S_SHIFT;
          start_frame_s = 1'b1;
          word_start_s  = 1'b1;
        end else begin
          state_nxt_s   = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt_s = S_IDLE;
          frame_end_s = 1'b1;
        end else begin
          do_sample_s = sample_s;
          // A shift edge right after a word boundary loads the next word;
          // with CPHA=1 the first leading edge only releases the preset MSB.
          if (shift_s && word_bnd_r) begin
            word_start_s = 1'b1;
          end else if (shift_s && skip_lead_r) begin
            skip_clr_s   = 1'b1;
          end else begin
            do_shift_s   = shift_s;
          end
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Transmit buffer, shifter, receive shifter, bit counter and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r    <= '0;
      word_bnd_r   <= 1'b0;
      skip_lead_r  <= 1'b0;
      rx_shift_r   <= '0;
      tx_shift_r   <= '0;
      tx_buf_r     <= '0;
      rx_data_r    <= '0;
      tx_ready_r   <= 1'b1;
      rx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      miso_r       <= 1'b0;
    end else begin
      rx_valid_r   <= 1'b0;
      frame_done_r <= frame_end_s;
      busy_r       <= (state_nxt_s == S_SHIFT);

      // A load in the same cycle as a word start is accepted; the word
      // start still takes the old (possibly empty) buffer.
      if (load_ok_s) begin
        tx_buf_r   <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end else if (word_start_s) begin
        tx_ready_r <= 1'b1;
      end else begin
        tx_ready_r <= tx_ready_r;
      end

      if (frame_end_s) begin
        miso_r     <= 1'b0;
      end else if (word_start_s) begin
        tx_shift_r <= tx_ready_r ? '0 : tx_buf_r;
        miso_r     <= ~tx_ready_r & tx_buf_r[DATA_W-1];
      end else if (do_shift_s) begin
        tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
        miso_r     <= tx_shift_r[DATA_W-2];
      end else begin
        miso_r     <= miso_r;
      end

      if (start_frame_s || frame_end_s) begin
        bit_cnt_r   <= '0;
        word_bnd_r  <= 1'b0;
        skip_lead_r <= CPHA & start_frame_s;
      end else begin
        if (do_sample_s) begin
          rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_r  <= {rx_shift_r[DATA_W-2:0], mosi_s};
            rx_valid_r <= 1'b1;
            bit_cnt_r  <= '0;
            word_bnd_r <= 1'b1;
          end else begin
            bit_cnt_r  <= bit_cnt_r + BW'(1);
          end
        end else if (word_start_s) begin
          word_bnd_r <= 1'b0;
        end else begin
          word_bnd_r <= word_bnd_r;
        end
        if (skip_clr_s) begin
          skip_lead_r <= 1'b0;
        end else begin
          skip_lead_r <= skip_lead_r;
        end
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_r;

  // One-clk flag for a word start that found the buffer empty
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= word_start_s & tx_ready_r;
    end
  end

  assign bus.tx_underrun = underrun_r;
`endif

  assign spi_miso       = miso_r;
  assign bus.tx_ready   = tx_ready_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (target) endpoint: the far-end counterpart of the team's SPI master, used on test boards and in loopback benches to answer master transactions. Oversamples the external SPI pins in the system clock domain, deserialises MOSI words to a parallel strobe interface, serialises a buffered transmit word onto MISO, and reports frame status with the same status/clear-pulse style as the master's control bus.

## Interface
- DATA_W, 8: word width in bits, 2..32, MSB first.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.

- clk  in  1  system clock; must run at least 8x SCLK.
- rst  in  1  synchronous reset, active-high.
- spi_sclk  in  1  SPI clock from master, asynchronous.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data; driven 0 while deselected (tristate is at top level).
- tx_data  in  DATA_W  next word to transmit.
- tx_load  in  1  single-cycle strobe; captures tx_data when tx_ready=1.
- tx_ready  out  1  transmit buffer empty.
- rx_data  out  DATA_W  last complete received word; held until the next word completes.
- rx_valid  out  1  single-cycle pulse, rx_data updated.
- busy  out  1  frame in progress (state SHIFT).
- frame_done  out  1  single-cycle pulse at end of frame.

## Operation
- spi_sclk, spi_cs_n, spi_mosi pass through 2-flop synchronizers; spi_sclk gets a 3rd flop for edge detect. Leading edge = CPOL -> !CPOL; trailing edge = the reverse.
- Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- States: S_IDLE, S_SHIFT.
- S_IDLE: bit_cnt=0, spi_miso=0. On synced cs_n falling -> S_SHIFT; word start: tx_shift <= tx_buf (0 if empty), buffer freed, spi_miso = tx_shift MSB.
- S_SHIFT, sample edge: rx_shift <= {rx_shift, mosi}; bit_cnt++. When bit_cnt was DATA_W-1: rx_data <= new rx_shift, rx_valid pulses, bit_cnt wraps to 0.
- S_SHIFT, shift edge: tx_shift shifts left, spi_miso takes the new MSB. The first shift edge after a word boundary instead starts the next word (reload from tx_buf). CPHA=1: the first leading edge of a frame does not shift.
- Synced cs_n rising in S_SHIFT -> S_IDLE. Partial word is discarded with no rx_valid. frame_done pulses once. A frame with zero edges still pulses frame_done.
- tx buffer: tx_load with tx_ready=1 captures tx_data, tx_ready=0 next cycle. tx_load with tx_ready=0 is ignored. A word start consumes the buffer, tx_ready=1 next cycle.
- Reset mid-frame: all state cleared. Block stays in S_IDLE until cs_n is seen high and then falls again; it never joins a frame mid-way.

## Timing
- Reset values: spi_miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_done=0.
- Pin edge to internal edge detect: 2-3 clk cycles (synchronizer uncertainty).
- rx_valid and rx_data update: 1 clk after the detected sample edge.
- spi_miso update: 1 clk after the detected shift edge or cs_n fall.
- busy rises 1 clk after detected cs_n fall and falls 1 clk after detected cs_n rise. frame_done is coincident with busy falling.
- Simultaneous tx_load and word start in the same cycle: the word start uses the old buffer (0 if empty) and the load is accepted; tx_ready stays 0.

## Configuration
- SPI_SLAVE_UNDERRUN_EN defined: adds output port tx_underrun (1 bit, reset 0). It pulses for one clk at each word start that finds tx_buf empty. Zeros are transmitted either way.
- SPI_SLAVE_UNDERRUN_EN undefined: the port is absent and underrun is silent.

## Structure
- Package spi_pkg holds spi_slave_state_t (S_IDLE, S_SHIFT) and the CPOL/CPHA mode localparams, shared with the SPI master.
- Sub-module spi_sync: parameterised-width 2-flop synchronizer, instantiated for the three input pins.

## Test plan
- Mode 0, DATA_W=8, tx preloaded 0xA5, master sends 0x3C -> MISO shows 0xA5 MSB first, rx_data=0x3C, one rx_valid pulse, one frame_done pulse.
- Modes 1, 2, 3, same transfer -> identical words on both sides.
- 3-word frame, tx_load issued on each tx_ready rise with 0x11, 0x22, 0x33; master sends 0x01, 0x02, 0x03 -> three rx_valid pulses in order, MISO carries 0x11, 0x22, 0x33, one frame_done.
- Frame with no tx_load -> MISO all zeros; with SPI_SLAVE_UNDERRUN_EN, one tx_underrun pulse per word.
- cs_n raised after 5 bits -> no rx_valid, rx_data unchanged, frame_done pulses.
- rst asserted at bit 3 and released while cs_n is still low -> busy=0 and all outputs at reset values. The remaining bits are ignored, and the next full frame is received correctly.
